// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests and
// loads the IF/ID pipeline register. It handles stall, flush and redirect, and
// works with multi-cycle memory through the imem_req/imem_ready handshake.
module fetch_stage #(
  parameter int unsigned   N        = 32,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic         clock,
  input  logic         reset_n,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [N-1:0] imem_rdata,
  input  logic         stall,
  input  logic         flush,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         ifid_valid,
  output logic [N-1:0] ifid_instr,
  output logic [N-1:0] ifid_pc,
  output logic [N-1:0] ifid_pc4
);

  typedef enum logic [1:0] {StFetch, StHold, StDrop} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] req_addr_q, req_addr_d;
  logic         req_q, req_d;
  logic [N-1:0] hold_q, hold_d;
  logic         valid_q, valid_d;
  logic [N-1:0] instr_q, instr_d;
  logic [N-1:0] ifpc_q, ifpc_d;
  logic [N-1:0] ifpc4_q, ifpc4_d;

  logic         complete;
  logic [N-1:0] pc_plus4;
  logic [N-1:0] target;

  assign complete = req_q & imem_ready;
  assign pc_plus4 = pc_q + N'(4);
  assign target   = {redirect_pc[N-1:2], 2'b00};

  assign imem_req   = req_q;
  assign imem_addr  = req_addr_q;
  assign ifid_valid = valid_q;
  assign ifid_instr = instr_q;
  assign ifid_pc    = ifpc_q;
  assign ifid_pc4   = ifpc4_q;

  // Next-state logic: redirect first, then per-state fetch handling, then flush.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    req_d      = req_q;
    hold_d     = hold_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    ifpc_d     = ifpc_q;
    ifpc4_d    = ifpc4_q;

    if (redirect) begin
      valid_d = 1'b0;
      pc_d    = target;
      hold_d  = '0;
      unique case (state_q)
        StFetch: begin
          if (req_q && !imem_ready) begin
            // Stale request still in flight: keep the address stable until it returns.
            state_d = StDrop;
          end else begin
            req_addr_d = target;
            req_d      = 1'b1;
          end
        end
        StHold: begin
          req_addr_d = target;
          req_d      = 1'b1;
          state_d    = StFetch;
        end
        StDrop: begin
          // Stale response arriving now is discarded; go straight to the newest target.
          if (complete) begin
            req_addr_d = target;
            state_d    = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          req_d = 1'b1;
          if (complete) begin
            if (stall && !flush) begin
              hold_d  = imem_rdata;
              req_d   = 1'b0;
              state_d = StHold;
            end else begin
              pc_d       = pc_plus4;
              req_addr_d = pc_plus4;
              valid_d    = 1'b1;
              instr_d    = imem_rdata;
              ifpc_d     = pc_q;
              ifpc4_d    = pc_plus4;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        StHold: begin
          if (!stall) begin
            pc_d       = pc_plus4;
            req_addr_d = pc_plus4;
            req_d      = 1'b1;
            valid_d    = 1'b1;
            instr_d    = hold_q;
            ifpc_d     = pc_q;
            ifpc4_d    = pc_plus4;
            state_d    = StFetch;
          end
        end
        StDrop: begin
          valid_d = 1'b0;
          if (complete) begin
            req_addr_d = pc_q;
            state_d    = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
      // Flush kills whatever IF/ID would hold, including a word completing now.
      if (flush) valid_d = 1'b0;
    end
  end

  // State and pipeline-register update with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      req_q      <= 1'b0;
      hold_q     <= '0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      ifpc_q     <= '0;
      ifpc4_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      req_q      <= req_d;
      hold_q     <= hold_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      ifpc_q     <= ifpc_d;
      ifpc4_q    <= ifpc4_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected IF/ID contents,
// a monitor pops and compares each newly loaded IF/ID entry.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;

  always #5 clock = ~clock;

  // Memory model: word[k] = k + 0x100.
  assign imem_rdata = (imem_addr >> 2) + 32'h100;

  fetch_stage #(
    .N        (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_pc4    (ifid_pc4)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic expect_word(input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] pc4);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.pc4   = pc4;
    exp_q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Monitor: a new IF/ID entry is a valid cycle after an invalid one or with a new pc.
  initial begin
    exp_t        e;
    logic        prev_valid;
    logic [31:0] prev_pc;
    prev_valid = 1'b0;
    prev_pc    = '0;
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        prev_valid = 1'b0;
      end else begin
        if (ifid_valid === 1'b1 && (!prev_valid || ifid_pc !== prev_pc)) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL ifid_unexpected: got instr %h pc %h pc4 %h, want no entry",
                     ifid_instr, ifid_pc, ifid_pc4);
          end else begin
            e = exp_q.pop_front();
            if (ifid_instr !== e.instr || ifid_pc !== e.pc || ifid_pc4 !== e.pc4) begin
              fails++;
              $display("FAIL ifid_entry: got instr %h pc %h pc4 %h, want instr %h pc %h pc4 %h",
                       ifid_instr, ifid_pc, ifid_pc4, e.instr, e.pc, e.pc4);
            end
          end
        end
        prev_valid = (ifid_valid === 1'b1);
        prev_pc    = ifid_pc;
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    imem_ready  = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    expect_word(32'h100, 32'h00, 32'h04);
    expect_word(32'h101, 32'h04, 32'h08);
    expect_word(32'h102, 32'h08, 32'h0C);
    expect_word(32'h103, 32'h0C, 32'h10);
    expect_word(32'h110, 32'h40, 32'h44);
    expect_word(32'h108, 32'h20, 32'h24);
    expect_word(32'h109, 32'h24, 32'h28);
    expect_word(32'h10B, 32'h2C, 32'h30);
    expect_word(32'h4000_00FF, 32'hFFFF_FFFC, 32'h0000_0000);
    expect_word(32'h100, 32'h00, 32'h04);
    expect_word(32'h100, 32'h00, 32'h04);
    expect_word(32'h101, 32'h04, 32'h08);

    // Reset state
    tick;
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_valid", {31'b0, ifid_valid}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", ifid_instr, 32'h0);
    tick;
    reset_n = 1'b1;

    // Streaming with ready high
    tick;  // E1
    check("e1_req", {31'b0, imem_req}, 32'h1);
    check("e1_addr", imem_addr, 32'h0);
    check("e1_valid", {31'b0, ifid_valid}, 32'h0);
    tick;  // E2
    check("e2_valid", {31'b0, ifid_valid}, 32'h1);
    tick;  // E3
    imem_ready = 1'b0;

    // Wait states at addr 8
    for (int i = 0; i < 3; i++) begin
      tick;
      check("wait_addr", imem_addr, 32'h8);
      check("wait_bubble", {31'b0, ifid_valid}, 32'h0);
    end
    imem_ready = 1'b1;
    tick;  // E7: 0x102 captured
    stall = 1'b1;

    // Stall as word at 12 completes
    for (int i = 0; i < 2; i++) begin
      tick;
      check("hold_req", {31'b0, imem_req}, 32'h0);
      check("hold_ifid_pc", ifid_pc, 32'h8);
      check("hold_valid", {31'b0, ifid_valid}, 32'h1);
    end
    stall = 1'b0;
    tick;  // E10: 0x103 from buffer
    check("resume_req", {31'b0, imem_req}, 32'h1);
    check("resume_addr", imem_addr, 32'h10);

    // Redirect while request at 0x10 outstanding
    imem_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick;  // E11
    check("drop_valid", {31'b0, ifid_valid}, 32'h0);
    check("drop_addr", imem_addr, 32'h10);
    check("drop_req", {31'b0, imem_req}, 32'h1);
    redirect = 1'b0;
    tick;  // E12
    check("drop_addr2", imem_addr, 32'h10);
    check("drop_valid2", {31'b0, ifid_valid}, 32'h0);
    imem_ready = 1'b1;
    tick;  // E13: stale word discarded
    check("redir_addr", imem_addr, 32'h40);
    check("redir_valid", {31'b0, ifid_valid}, 32'h0);
    tick;  // E14: 0x110 at 0x40
    stall = 1'b1;
    tick;  // E15: word at 0x44 buffered
    check("hold2_req", {31'b0, imem_req}, 32'h0);
    check("hold2_ifid_pc", ifid_pc, 32'h40);

    // Redirect from HOLD to unaligned target
    redirect    = 1'b1;
    redirect_pc = 32'h23;
    tick;  // E16
    check("hredir_valid", {31'b0, ifid_valid}, 32'h0);
    check("hredir_addr", imem_addr, 32'h20);
    check("hredir_req", {31'b0, imem_req}, 32'h1);
    redirect = 1'b0;
    stall    = 1'b0;
    tick;  // E17
    tick;  // E18
    flush = 1'b1;
    tick;  // E19: word at 0x28 dropped, pc advances
    check("flush_valid", {31'b0, ifid_valid}, 32'h0);
    check("flush_addr", imem_addr, 32'h2C);
    flush = 1'b0;
    tick;  // E20

    // Wrap-around at top of address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick;  // E21
    check("wrap_valid", {31'b0, ifid_valid}, 32'h0);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick;  // E22
    tick;  // E23

    // Async reset in the middle of DROP
    imem_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    tick;  // E24
    check("drop3_addr", imem_addr, 32'h4);
    check("drop3_valid", {31'b0, ifid_valid}, 32'h0);
    redirect = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_req", {31'b0, imem_req}, 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_valid", {31'b0, ifid_valid}, 32'h0);
    check("arst_instr", ifid_instr, 32'h0);
    check("arst_pc", ifid_pc, 32'h0);
    check("arst_pc4", ifid_pc4, 32'h0);
    imem_ready = 1'b1;
    tick;
    tick;
    reset_n = 1'b1;
    tick;  // E1'
    check("rst2_req", {31'b0, imem_req}, 32'h1);
    check("rst2_addr", imem_addr, 32'h0);
    tick;  // E2': 0x100
    check("rst2_valid", {31'b0, ifid_valid}, 32'h1);
    tick;  // E3': 0x101
    stall = 1'b1;
    tick;
    tick;

    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
